sr_pulse_conditioner: RTL and testbench

//  Upstream front-end for the SR latch stage. Takes two raw, asynchronous,

---
 rtl/sr_pulse_conditioner_if.sv | 28 ++
 rtl/sr_pulse_conditioner.sv | 156 +++++++++++++++
 tb/tb_sr_pulse_conditioner.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pulse_conditioner_if.sv
// Button-side inputs and latch-side outputs of the SR pulse conditioner.
// The master drives the raw buttons; the slave (the conditioner) drives the latch controls.
interface sr_pulse_conditioner_if;
    logic set_in;
    logic reset_in;
    logic S;
    logic R;
    logic busy;
    logic dropped;

    modport master (
        output set_in,
        output reset_in,
        input  S,
        input  R,
        input  busy,
        input  dropped
    );

    modport slave (
        input  set_in,
        input  reset_in,
        output S,
        output R,
        output busy,
        output dropped
    );
endinterface

// File: rtl/sr_pulse_conditioner.sv
// Turns two bouncing async buttons into clean, mutually exclusive S/R pulses.
// Each channel is synchronised, debounced and edge-detected; a shared FSM arbitrates and shapes the pulse.
module sr_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 1,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter bit SET_PRIORITY    = 1'b0
) (
    input logic                   clk,
    input logic                   rst_n,
    sr_pulse_conditioner_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int PH_MAX = (PULSE_WIDTH > HOLDOFF_CYCLES) ? PULSE_WIDTH : HOLDOFF_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam logic [PH_W-1:0] PW_LAST = PH_W'(PULSE_WIDTH - 1);
    localparam logic [PH_W-1:0] HO_LAST = PH_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HOLDOFF
    } state_t;

    // Channel 0 is set, channel 1 is reset.
    logic [1:0] raw;
    logic [1:0] rise;

    assign raw = {bus.reset_in, bus.set_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_q_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             deb_next;
            logic [CNT_W-1:0] cnt_next;

            // A new level must persist for DEBOUNCE_CYCLES consecutive cycles; any return restarts the count.
            always_comb begin
                deb_next = deb_reg;
                cnt_next = '0;
                if (sync2_reg != deb_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        deb_next = sync2_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_q_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_reg   <= deb_next;
                    deb_q_reg <= deb_reg;
                    cnt_reg   <= cnt_next;
                end
            end

            assign rise[gi] = deb_reg & ~deb_q_reg;
        end
    endgenerate

    state_t          state_reg;
    state_t          state_next;
    logic [PH_W-1:0] phase_reg;
    logic [PH_W-1:0] phase_next;
    logic            s_reg;
    logic            s_next;
    logic            r_reg;
    logic            r_next;
    logic            dropped_reg;
    logic            dropped_next;

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg + PH_W'(1);
        s_next       = 1'b0;
        r_next       = 1'b0;
        dropped_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                phase_next = '0;
                if (|rise) begin
                    state_next = ST_PULSE;
                    if (&rise) begin
                        s_next       = SET_PRIORITY;
                        r_next       = ~SET_PRIORITY;
                        dropped_next = 1'b1;
                    end else begin
                        s_next = rise[0];
                        r_next = rise[1];
                    end
                end
            end
            ST_PULSE: begin
                // Edges arriving while busy are discarded, never queued.
                dropped_next = |rise;
                s_next       = s_reg;
                r_next       = r_reg;
                if (phase_reg == PW_LAST) begin
                    s_next     = 1'b0;
                    r_next     = 1'b0;
                    phase_next = '0;
                    state_next = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                dropped_next = |rise;
                if (phase_reg == HO_LAST) begin
                    phase_next = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                phase_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= '0;
            s_reg       <= 1'b0;
            r_reg       <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            s_reg       <= s_next;
            r_reg       <= r_next;
            dropped_reg <= dropped_next;
        end
    end

    assign bus.S       = s_reg;
    assign bus.R       = r_reg;
    assign bus.dropped = dropped_reg;
    assign bus.busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sr_pulse_conditioner.sv
// Self-checking bench: directed latency/arbitration/reset scenarios plus a long
// random bouncing run checked against a timing-arithmetic reference model.
module tb_sr_pulse_conditioner;

    localparam int D      = 4;
    localparam int PW     = 1;
    localparam int HO     = 2;
    localparam int NRAND  = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst_n2 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bit raw_hist [2][NRAND];

    sr_pulse_conditioner_if bus ();
    sr_pulse_conditioner_if bus2 ();

    sr_pulse_conditioner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Second instance: wide pulse, no hold-off, set wins ties.
    sr_pulse_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_WIDTH     (3),
        .HOLDOFF_CYCLES  (0),
        .SET_PRIORITY    (1'b1)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.set_in = 1'b0;  bus.reset_in = 1'b0;
        bus2.set_in = 1'b0; bus2.reset_in = 1'b0;
        #2;
        rst_n = 1'b0; rst_n2 = 1'b0;
        tick();
        bus.set_in = 1'b1;
        bus2.reset_in = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (bus.S !== 1'b0 || bus.R !== 1'b0 || bus.busy !== 1'b0 || bus.dropped !== 1'b0) begin
                errors++;
                $display("FAIL reset.main cycle %0d: got S=%b R=%b busy=%b dropped=%b required all 0",
                         e, bus.S, bus.R, bus.busy, bus.dropped);
            end
            checks++;
            if (bus2.S !== 1'b0 || bus2.R !== 1'b0 || bus2.busy !== 1'b0 || bus2.dropped !== 1'b0) begin
                errors++;
                $display("FAIL reset.pw3 cycle %0d: got S=%b R=%b busy=%b dropped=%b required all 0",
                         e, bus2.S, bus2.R, bus2.busy, bus2.dropped);
            end
        end
        bus.set_in = 1'b0;
        bus2.reset_in = 1'b0;
        tick();
        rst_n = 1'b1; rst_n2 = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        $display("test_reset done");
    endtask

    task automatic test_clean_set();
        logic exp_s, exp_busy;
        bus.set_in = 1'b1;   // first sampled on edge 0
        for (int e = 0; e <= 12; e++) begin
            tick();
            exp_s    = (e == D + 2);
            exp_busy = (e >= D + 2) && (e < D + 2 + PW + HO);
            checks++;
            if (bus.S !== exp_s) begin
                errors++;
                $display("FAIL clean_set.S edge %0d: got %b required %b", e, bus.S, exp_s);
            end
            checks++;
            if (bus.R !== 1'b0) begin
                errors++;
                $display("FAIL clean_set.R edge %0d: got %b required 0", e, bus.R);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL clean_set.busy edge %0d: got %b required %b", e, bus.busy, exp_busy);
            end
        end
        bus.set_in = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (bus.S !== 1'b0 || bus.R !== 1'b0) begin
                errors++;
                $display("FAIL clean_set.release edge %0d: got S=%b R=%b required 0 0", e, bus.S, bus.R);
            end
        end
        $display("test_clean_set done");
    endtask

    task automatic test_bounce();
        logic [3:0] pattern;
        logic       exp_s;
        pattern = 4'b0101;   // bit e is the level sampled on edge e
        for (int e = 0; e <= 16; e++) begin
            bus.set_in = (e < 4) ? pattern[e] : 1'b1;
            tick();
            exp_s = (e == 4 + D + 2);
            checks++;
            if (bus.S !== exp_s) begin
                errors++;
                $display("FAIL bounce.S edge %0d: got %b required %b", e, bus.S, exp_s);
            end
            checks++;
            if (bus.R !== 1'b0) begin
                errors++;
                $display("FAIL bounce.R edge %0d: got %b required 0", e, bus.R);
            end
        end
        bus.set_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
        $display("test_bounce done");
    endtask

    task automatic test_simultaneous();
        logic exp_r, exp_s2, exp_drop;
        bus.set_in = 1'b1;  bus.reset_in = 1'b1;
        bus2.set_in = 1'b1; bus2.reset_in = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            tick();
            exp_r    = (e == D + 2);
            exp_drop = (e == D + 2);
            exp_s2   = (e >= D + 2) && (e < D + 2 + 3);
            checks++;
            if (bus.R !== exp_r || bus.S !== 1'b0) begin
                errors++;
                $display("FAIL simul.main edge %0d: got S=%b R=%b required S=0 R=%b", e, bus.S, bus.R, exp_r);
            end
            checks++;
            if (bus.dropped !== exp_drop) begin
                errors++;
                $display("FAIL simul.main_dropped edge %0d: got %b required %b", e, bus.dropped, exp_drop);
            end
            checks++;
            if (bus2.S !== exp_s2 || bus2.R !== 1'b0) begin
                errors++;
                $display("FAIL simul.setprio edge %0d: got S=%b R=%b required S=%b R=0", e, bus2.S, bus2.R, exp_s2);
            end
            checks++;
            if (bus2.dropped !== exp_drop || bus2.busy !== exp_s2) begin
                errors++;
                $display("FAIL simul.setprio_flags edge %0d: got dropped=%b busy=%b required %b %b",
                         e, bus2.dropped, bus2.busy, exp_drop, exp_s2);
            end
        end
        bus.set_in = 1'b0;  bus.reset_in = 1'b0;
        bus2.set_in = 1'b0; bus2.reset_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_holdoff();
        logic exp_r, exp_drop;
        bus.reset_in = 1'b1;   // reset level first sampled on edge 0, set on edge 1
        tick();
        bus.set_in = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_r    = (e == D + 2);
            exp_drop = (e == D + 3);
            checks++;
            if (bus.R !== exp_r || bus.S !== 1'b0) begin
                errors++;
                $display("FAIL holdoff.out edge %0d: got S=%b R=%b required S=0 R=%b", e, bus.S, bus.R, exp_r);
            end
            checks++;
            if (bus.dropped !== exp_drop) begin
                errors++;
                $display("FAIL holdoff.dropped edge %0d: got %b required %b", e, bus.dropped, exp_drop);
            end
        end
        bus.set_in = 1'b0; bus.reset_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
        $display("test_holdoff done");
    endtask

    task automatic test_async_reset();
        logic exp_s;
        bus2.set_in = 1'b1;
        for (int e = 0; e <= 7; e++) tick();
        checks++;
        if (bus2.S !== 1'b1) begin
            errors++;
            $display("FAIL async_reset.midpulse: got S=%b required 1", bus2.S);
        end
        #2;
        rst_n2 = 1'b0;
        #1;
        checks++;
        if (bus2.S !== 1'b0 || bus2.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset.immediate: got S=%b busy=%b required 0 0", bus2.S, bus2.busy);
        end
        tick();
        tick();
        rst_n2 = 1'b1;   // next edge is edge 0 for the held button
        for (int e = 0; e <= 12; e++) begin
            tick();
            exp_s = (e >= D + 2) && (e < D + 2 + 3);
            checks++;
            if (bus2.S !== exp_s || bus2.R !== 1'b0) begin
                errors++;
                $display("FAIL async_reset.after edge %0d: got S=%b R=%b required S=%b R=0", e, bus2.S, bus2.R, exp_s);
            end
        end
        bus2.set_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        bit tgt [2];
        bit m_deb [2];
        int run [2];
        int rose_at [2];
        bit rz [2];
        bit sv;
        int start, ready_at;
        bit sel_set, exp_s, exp_r, exp_busy, exp_drop, prev_s, prev_r;
        int m_s_pulses, m_r_pulses, d_s_pulses, d_r_pulses;

        for (int c = 0; c < 2; c++) begin
            tgt[c] = 1'b0; m_deb[c] = 1'b0; run[c] = 0; rose_at[c] = -10;
        end
        start = -1000; ready_at = 0; sel_set = 1'b0;
        m_s_pulses = 0; m_r_pulses = 0; d_s_pulses = 0; d_r_pulses = 0;
        prev_s = 1'b0; prev_r = 1'b0;

        bus.set_in = 1'b0; bus.reset_in = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;   // edge n of the loop below is model edge n

        for (int n = 0; n < NRAND; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(39) == 0) tgt[c] = ~tgt[c];
                raw_hist[c][n] = ($urandom_range(5) == 0) ? ~tgt[c] : tgt[c];
            end
            bus.set_in   = raw_hist[0][n];
            bus.reset_in = raw_hist[1][n];
            tick();

            // Arbiter sees a rise one edge after the debounced level goes high.
            for (int c = 0; c < 2; c++) rz[c] = (rose_at[c] == n - 1);
            // Debounced level follows the 2-edge-delayed raw level once it has differed for D edges in a row.
            for (int c = 0; c < 2; c++) begin
                sv = (n >= 2) ? raw_hist[c][n-2] : 1'b0;
                if (sv != m_deb[c]) begin
                    run[c]++;
                    if (run[c] == D) begin
                        m_deb[c] = sv;
                        run[c] = 0;
                        if (sv) rose_at[c] = n;
                    end
                end else begin
                    run[c] = 0;
                end
            end

            exp_drop = 1'b0;
            if (rz[0] || rz[1]) begin
                if (n >= ready_at) begin
                    if (rz[0] && rz[1]) begin
                        sel_set  = 1'b0;
                        exp_drop = 1'b1;
                    end else begin
                        sel_set = rz[0];
                    end
                    start    = n;
                    ready_at = n + PW + HO + 1;
                    if (sel_set) m_s_pulses++;
                    else         m_r_pulses++;
                end else begin
                    exp_drop = 1'b1;
                end
            end
            exp_s    = sel_set  && (n >= start) && (n < start + PW);
            exp_r    = !sel_set && (n >= start) && (n < start + PW);
            exp_busy = (n >= start) && (n < start + PW + HO);

            checks++;
            if ((bus.S & bus.R) !== 1'b0) begin
                errors++;
                $display("FAIL random.exclusive edge %0d: got S=%b R=%b required S&R=0", n, bus.S, bus.R);
            end
            checks++;
            if (bus.S !== exp_s || bus.R !== exp_r) begin
                errors++;
                $display("FAIL random.out edge %0d: got S=%b R=%b required S=%b R=%b", n, bus.S, bus.R, exp_s, exp_r);
            end
            checks++;
            if (bus.busy !== exp_busy || bus.dropped !== exp_drop) begin
                errors++;
                $display("FAIL random.flags edge %0d: got busy=%b dropped=%b required %b %b",
                         n, bus.busy, bus.dropped, exp_busy, exp_drop);
            end
            if (bus.S && !prev_s) d_s_pulses++;
            if (bus.R && !prev_r) d_r_pulses++;
            prev_s = bus.S;
            prev_r = bus.R;
        end

        checks++;
        if (d_s_pulses !== m_s_pulses || d_r_pulses !== m_r_pulses) begin
            errors++;
            $display("FAIL random.pulse_count: got S=%0d R=%0d required S=%0d R=%0d",
                     d_s_pulses, d_r_pulses, m_s_pulses, m_r_pulses);
        end
        $display("test_random done: %0d S pulses, %0d R pulses", d_s_pulses, d_r_pulses);
        bus.set_in = 1'b0; bus.reset_in = 1'b0;
        for (int e = 0; e < 12; e++) tick();
    endtask

    initial begin
        test_reset();
        test_clean_set();
        test_bounce();
        test_simultaneous();
        test_holdoff();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
